// File: rtl/l1_fill_responder_pkg.sv
// Shared types for the L1 fill/snoop responder: MESI encoding, line and command payloads, opcodes, FSM states.
package l1_fill_responder_pkg;

    localparam int unsigned TAG_W = 12;
    localparam int unsigned IDX_W = 14;
    localparam int unsigned OFF_W = 6;
    localparam int unsigned LRU_W = 3;
    localparam int unsigned CMD_W = 4;

    typedef enum logic [1:0] {
        MESI_I = 2'd0,
        MESI_S = 2'd1,
        MESI_E = 2'd2,
        MESI_M = 2'd3
    } mesi_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [LRU_W-1:0] lru;
        mesi_t            mesi;
    } cache_line_t;

    typedef struct packed {
        logic [CMD_W-1:0] n;
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] index;
        logic [OFF_W-1:0] offset;
    } command_t;

    localparam logic [CMD_W-1:0] CMD_RD_DATA     = 4'd0;
    localparam logic [CMD_W-1:0] CMD_WR_DATA     = 4'd1;
    localparam logic [CMD_W-1:0] CMD_RD_INSTR    = 4'd2;
    localparam logic [CMD_W-1:0] CMD_SNOOP_INVAL = 4'd3;
    localparam logic [CMD_W-1:0] CMD_SNOOP_RD    = 4'd4;
    localparam logic [CMD_W-1:0] CMD_CLEAR       = 4'd8;
    localparam logic [CMD_W-1:0] CMD_PRINT       = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_WB   = 2'd2,
        ST_RESP = 2'd3
    } resp_state_t;

endpackage

// File: rtl/l1_fill_responder_sat_counter.sv
// Saturating event counter with synchronous clear (clear wins over increment).
module l1_fill_responder_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/l1_fill_responder.sv
// Far end of the L1 miss/snoop interface: models L2 latency, writes back dirty victims, returns the fill line.
module l1_fill_responder
    import l1_fill_responder_pkg::*;
#(
    parameter int unsigned L2_LATENCY = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  command_t         req_cmd,
    input  cache_line_t      req_line,
    input  logic             snoop_hit,
    output logic             wb_valid,
    input  logic             wb_ready,
    output cache_line_t      wb_line,
    output logic             resp_valid,
    input  logic             resp_ready,
    output cache_line_t      resp_line,
    output logic [CNT_W-1:0] stat_reads,
    output logic [CNT_W-1:0] stat_writes,
    output logic [CNT_W-1:0] stat_wbs,
    output logic [CNT_W-1:0] stat_invals
);

    localparam int unsigned LAT_W = (L2_LATENCY > 1) ? $clog2(L2_LATENCY) : 1;

    resp_state_t      state_q, state_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [CMD_W-1:0] n_q, n_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    cache_line_t      victim_q, victim_d;
    logic             shared_q, shared_d;
    logic             req_ready_q, req_ready_d;
    logic             wb_valid_q, wb_valid_d;
    logic             resp_valid_q, resp_valid_d;
    cache_line_t      wb_line_q, wb_line_d;
    cache_line_t      resp_line_q, resp_line_d;

    logic             accept_c;
    logic             start_c;
    cache_line_t      fill_line_c;
    logic             unused_addr;

    // Victim must go back to L2 before the new line is installed.
    function automatic logic needs_wb(input logic [CMD_W-1:0] n, input cache_line_t victim,
                                      input logic [TAG_W-1:0] tag);
        case (n)
            CMD_RD_DATA, CMD_WR_DATA, CMD_RD_INSTR:
                needs_wb = (victim.mesi == MESI_M) && (victim.tag != tag);
            CMD_SNOOP_RD: needs_wb = (victim.mesi == MESI_M);
            default:      needs_wb = 1'b0;
        endcase
    endfunction

    function automatic mesi_t fill_mesi(input logic [CMD_W-1:0] n, input cache_line_t victim,
                                        input logic [TAG_W-1:0] tag, input logic shared);
        logic hit;
        hit = (victim.mesi != MESI_I) && (victim.tag == tag);
        case (n)
            CMD_RD_DATA:     fill_mesi = hit ? victim.mesi : (shared ? MESI_S : MESI_E);
            CMD_WR_DATA:     fill_mesi = MESI_M;
            CMD_RD_INSTR:    fill_mesi = shared ? MESI_S : MESI_E;
            CMD_SNOOP_INVAL: fill_mesi = MESI_I;
            CMD_SNOOP_RD:    fill_mesi = ((victim.mesi == MESI_M) || (victim.mesi == MESI_E))
                                         ? MESI_S : victim.mesi;
            default:         fill_mesi = victim.mesi;
        endcase
    endfunction

    assign accept_c    = req_valid & req_ready_q;
    assign unused_addr = ^{req_cmd.index, req_cmd.offset};

    // Only opcodes 0-4 open a transaction; 8/9 and unknown opcodes are swallowed in IDLE.
    always_comb begin
        start_c = 1'b0;
        case (req_cmd.n)
            CMD_RD_DATA, CMD_WR_DATA, CMD_RD_INSTR, CMD_SNOOP_INVAL, CMD_SNOOP_RD: start_c = accept_c;
            CMD_CLEAR, CMD_PRINT: start_c = 1'b0;
            default:              start_c = 1'b0;
        endcase
    end

    always_comb begin
        fill_line_c      = '0;
        fill_line_c.tag  = tag_q;
        fill_line_c.lru  = '0;
        fill_line_c.mesi = fill_mesi(n_q, victim_q, tag_q, shared_q);
    end

    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        n_d         = n_q;
        tag_d       = tag_q;
        victim_d    = victim_q;
        shared_d    = shared_q;
        wb_line_d   = wb_line_q;
        resp_line_d = resp_line_q;
        case (state_q)
            ST_IDLE: begin
                if (start_c) begin
                    n_d      = req_cmd.n;
                    tag_d    = req_cmd.tag;
                    victim_d = req_line;
                    shared_d = snoop_hit;
                    lat_d    = LAT_W'(L2_LATENCY - 1);
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (lat_q == '0) begin
                    if (needs_wb(n_q, victim_q, tag_q)) begin
                        wb_line_d = victim_q;
                        state_d   = ST_WB;
                    end else begin
                        resp_line_d = fill_line_c;
                        state_d     = ST_RESP;
                    end
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            ST_WB: begin
                if (wb_ready) begin
                    resp_line_d = fill_line_c;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        req_ready_d  = (state_d == ST_IDLE);
        wb_valid_d   = (state_d == ST_WB);
        resp_valid_d = (state_d == ST_RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            lat_q        <= '0;
            n_q          <= '0;
            tag_q        <= '0;
            victim_q     <= '0;
            shared_q     <= 1'b0;
            req_ready_q  <= 1'b1;
            wb_valid_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            wb_line_q    <= '0;
            resp_line_q  <= '0;
        end else begin
            state_q      <= state_d;
            lat_q        <= lat_d;
            n_q          <= n_d;
            tag_q        <= tag_d;
            victim_q     <= victim_d;
            shared_q     <= shared_d;
            req_ready_q  <= req_ready_d;
            wb_valid_q   <= wb_valid_d;
            resp_valid_q <= resp_valid_d;
            wb_line_q    <= wb_line_d;
            resp_line_q  <= resp_line_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign wb_valid   = wb_valid_q;
    assign wb_line    = wb_line_q;
    assign resp_valid = resp_valid_q;
    assign resp_line  = resp_line_q;

    // Bus statistics; opcode 8 clears all four on its accept edge.
    l1_fill_responder_sat_counter #(.CNT_W(CNT_W)) u_cnt_reads (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (accept_c && ((req_cmd.n == CMD_RD_DATA) || (req_cmd.n == CMD_RD_INSTR))),
        .clr   (accept_c && (req_cmd.n == CMD_CLEAR)),
        .count (stat_reads)
    );

    l1_fill_responder_sat_counter #(.CNT_W(CNT_W)) u_cnt_writes (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (accept_c && (req_cmd.n == CMD_WR_DATA)),
        .clr   (accept_c && (req_cmd.n == CMD_CLEAR)),
        .count (stat_writes)
    );

    l1_fill_responder_sat_counter #(.CNT_W(CNT_W)) u_cnt_wbs (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (wb_valid_q && wb_ready),
        .clr   (accept_c && (req_cmd.n == CMD_CLEAR)),
        .count (stat_wbs)
    );

    l1_fill_responder_sat_counter #(.CNT_W(CNT_W)) u_cnt_invals (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (accept_c && (req_cmd.n == CMD_SNOOP_INVAL)),
        .clr   (accept_c && (req_cmd.n == CMD_CLEAR)),
        .count (stat_invals)
    );

endmodule

// File: tb/tb_l1_fill_responder.sv
// Directed bench for l1_fill_responder: latency, writeback, MESI mapping, backpressure, stats and saturation.
module tb_l1_fill_responder;
    import l1_fill_responder_pkg::*;

    localparam int unsigned LINE_W = $bits(cache_line_t);

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, snoop_hit;
    command_t    req_cmd;
    cache_line_t req_line, wb_line, resp_line;
    logic        wb_valid, wb_ready, resp_valid, resp_ready;
    logic [15:0] stat_reads, stat_writes, stat_wbs, stat_invals;

    logic        r2_valid, r2_ready, r2_snoop, r2_wb_valid, r2_wb_ready, r2_resp_valid, r2_resp_ready;
    command_t    r2_cmd;
    cache_line_t r2_line, r2_wb_line, r2_resp_line;
    logic [1:0]  r2_reads, r2_writes, r2_wbs, r2_invals;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    l1_fill_responder #(.L2_LATENCY(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_line(req_line), .snoop_hit(snoop_hit),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_line(wb_line),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_line(resp_line),
        .stat_reads(stat_reads), .stat_writes(stat_writes), .stat_wbs(stat_wbs), .stat_invals(stat_invals)
    );

    l1_fill_responder #(.L2_LATENCY(1), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .req_valid(r2_valid), .req_ready(r2_ready),
        .req_cmd(r2_cmd), .req_line(r2_line), .snoop_hit(r2_snoop),
        .wb_valid(r2_wb_valid), .wb_ready(r2_wb_ready), .wb_line(r2_wb_line),
        .resp_valid(r2_resp_valid), .resp_ready(r2_resp_ready), .resp_line(r2_resp_line),
        .stat_reads(r2_reads), .stat_writes(r2_writes), .stat_wbs(r2_wbs), .stat_invals(r2_invals)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ln(input cache_line_t l);
        return {{(64-LINE_W){1'b0}}, l};
    endfunction

    function automatic command_t mk_cmd(input logic [CMD_W-1:0] n, input logic [TAG_W-1:0] tag);
        command_t c;
        c.n = n; c.tag = tag; c.index = 14'h0a5; c.offset = 6'h03;
        return c;
    endfunction

    function automatic cache_line_t mk_line(input logic [TAG_W-1:0] tag, input logic [LRU_W-1:0] lru,
                                            input mesi_t m);
        cache_line_t l;
        l.tag = tag; l.lru = lru; l.mesi = m;
        return l;
    endfunction

    // One full transaction; an ignored write request is held during the response stall.
    task automatic run_txn(input command_t c, input cache_line_t v, input logic sh,
                           input int wb_stall, input int rsp_stall,
                           output int lat, output int n_wb, output cache_line_t wbl, output cache_line_t rl);
        int cyc;
        bit done, both, wb_bad, bp_bad;
        lat = -1; n_wb = 0; wbl = '0; rl = '0; cyc = 0;
        done = 1'b0; both = 1'b0; wb_bad = 1'b0; bp_bad = 1'b0;
        req_cmd = c; req_line = v; snoop_hit = sh; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        while (!done) begin
            if (wb_valid && resp_valid) both = 1'b1;
            if (cyc > 64) begin
                check("resp_timeout", 64'(resp_valid), 64'(1));
                done = 1'b1;
            end else if (wb_valid) begin
                n_wb++;
                wbl = wb_line;
                repeat (wb_stall) begin
                    @(posedge clk); #1; cyc++;
                    if ((wb_line !== wbl) || !wb_valid || resp_valid) wb_bad = 1'b1;
                end
                wb_ready = 1'b1;
                @(posedge clk); #1; cyc++;
                wb_ready = 1'b0;
            end else if (resp_valid) begin
                lat = cyc;
                rl  = resp_line;
                req_cmd = mk_cmd(CMD_WR_DATA, 12'hfff); req_valid = 1'b1;
                repeat (rsp_stall) begin
                    @(posedge clk); #1; cyc++;
                    if ((resp_line !== rl) || !resp_valid || req_ready || wb_valid) bp_bad = 1'b1;
                end
                resp_ready = 1'b1;
                @(posedge clk); #1;
                resp_ready = 1'b0; req_valid = 1'b0;
                check("ready_after_resp", 64'(req_ready), 64'(1));
                done = 1'b1;
            end else begin
                @(posedge clk); #1; cyc++;
            end
        end
        check("wb_resp_exclusive", 64'(both), 64'(0));
        check("wb_line_stable", 64'(wb_bad), 64'(0));
        check("resp_line_stable", 64'(bp_bad), 64'(0));
    endtask

    task automatic send_only(input command_t c);
        bit seen;
        seen = 1'b0;
        req_cmd = c; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (6) begin
            if (resp_valid || wb_valid || !req_ready) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("no_resp_quiet", 64'(seen), 64'(0));
    endtask

    initial begin
        int lat, n_wb, cyc;
        cache_line_t wbl, rl;
        bit seen;

        rst_n = 1'b0;
        req_valid = 1'b0; req_cmd = '0; req_line = '0; snoop_hit = 1'b0;
        wb_ready = 1'b0; resp_ready = 1'b0;
        r2_valid = 1'b0; r2_cmd = '0; r2_line = '0; r2_snoop = 1'b0;
        r2_wb_ready = 1'b1; r2_resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_ready", 64'(req_ready), 64'(1));

        // Asynchronous reset in the middle of a dirty write miss
        req_cmd = mk_cmd(CMD_WR_DATA, 12'h034); req_line = mk_line(12'h012, 3'd0, MESI_M);
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("mid_busy", 64'(req_ready), 64'(0));
        check("mid_writes", 64'(stat_writes), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check("async_ready", 64'(req_ready), 64'(1));
        check("async_resp_valid", 64'(resp_valid), 64'(0));
        check("async_wb_valid", 64'(wb_valid), 64'(0));
        check("async_stats", 64'({stat_reads, stat_writes, stat_wbs, stat_invals}), 64'(0));
        @(posedge clk); #1 rst_n = 1'b1;
        wb_ready = 1'b1; resp_ready = 1'b1; seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (wb_valid || resp_valid) seen = 1'b1;
        end
        wb_ready = 1'b0; resp_ready = 1'b0;
        check("no_partial_after_reset", 64'(seen), 64'(0));
        check("wbs_after_reset", 64'(stat_wbs), 64'(0));

        // Read miss, clean victim
        run_txn(mk_cmd(CMD_RD_DATA, 12'h034), mk_line(12'h012, 3'b101, MESI_E), 1'b0, 0, 0, lat, n_wb, wbl, rl);
        check("rd_latency", 64'(lat), 64'(4));
        check("rd_no_wb", 64'(n_wb), 64'(0));
        check("rd_line", ln(rl), ln(mk_line(12'h034, 3'd0, MESI_E)));
        check("rd_stat_reads", 64'(stat_reads), 64'(1));

        // Write miss, dirty victim, L2 stalls the writeback 3 cycles
        run_txn(mk_cmd(CMD_WR_DATA, 12'h034), mk_line(12'h012, 3'b010, MESI_M), 1'b0, 3, 0, lat, n_wb, wbl, rl);
        check("wr_wb_count", 64'(n_wb), 64'(1));
        check("wr_wb_line", ln(wbl), ln(mk_line(12'h012, 3'b010, MESI_M)));
        check("wr_line", ln(rl), ln(mk_line(12'h034, 3'd0, MESI_M)));
        check("wr_stat_wbs", 64'(stat_wbs), 64'(1));
        check("wr_stat_writes", 64'(stat_writes), 64'(1));

        // Snoop read on a Modified line
        run_txn(mk_cmd(CMD_SNOOP_RD, 12'h034), mk_line(12'h034, 3'b001, MESI_M), 1'b0, 0, 0, lat, n_wb, wbl, rl);
        check("snp_wb_count", 64'(n_wb), 64'(1));
        check("snp_line", ln(rl), ln(mk_line(12'h034, 3'd0, MESI_S)));
        check("snp_stat_wbs", 64'(stat_wbs), 64'(2));
        check("snp_stat_reads", 64'(stat_reads), 64'(1));

        // Snoop read on an Exclusive line: downgrade, no writeback
        run_txn(mk_cmd(CMD_SNOOP_RD, 12'h077), mk_line(12'h077, 3'b110, MESI_E), 1'b0, 0, 0, lat, n_wb, wbl, rl);
        check("snpe_wb_count", 64'(n_wb), 64'(0));
        check("snpe_line", ln(rl), ln(mk_line(12'h077, 3'd0, MESI_S)));

        // Snoop invalidate
        run_txn(mk_cmd(CMD_SNOOP_INVAL, 12'h034), mk_line(12'h034, 3'b100, MESI_S), 1'b0, 0, 0, lat, n_wb, wbl, rl);
        check("inv_wb_count", 64'(n_wb), 64'(0));
        check("inv_line", ln(rl), ln(mk_line(12'h034, 3'd0, MESI_I)));
        check("inv_stat_invals", 64'(stat_invals), 64'(1));

        // Instruction read, shared, response held off 5 cycles
        run_txn(mk_cmd(CMD_RD_INSTR, 12'h066), mk_line(12'h055, 3'd0, MESI_I), 1'b1, 0, 5, lat, n_wb, wbl, rl);
        check("bp_latency", 64'(lat), 64'(4));
        check("bp_line", ln(rl), ln(mk_line(12'h066, 3'd0, MESI_S)));
        check("bp_stat_reads", 64'(stat_reads), 64'(2));
        check("bp_stat_writes", 64'(stat_writes), 64'(1));

        // Read hit on a Modified line keeps M and needs no writeback
        run_txn(mk_cmd(CMD_RD_DATA, 12'h034), mk_line(12'h034, 3'b011, MESI_M), 1'b1, 0, 0, lat, n_wb, wbl, rl);
        check("hit_wb_count", 64'(n_wb), 64'(0));
        check("hit_line", ln(rl), ln(mk_line(12'h034, 3'd0, MESI_M)));
        check("hit_stat_reads", 64'(stat_reads), 64'(3));

        // Unknown opcode and print: swallowed, no stat change
        send_only(mk_cmd(4'd5, 12'h001));
        send_only(mk_cmd(CMD_PRINT, 12'h002));
        check("nop_stats", 64'({stat_reads, stat_writes, stat_wbs, stat_invals}),
              64'({16'd3, 16'd1, 16'd2, 16'd1}));

        // Clear
        send_only(mk_cmd(CMD_CLEAR, 12'h003));
        check("clr_stats", 64'({stat_reads, stat_writes, stat_wbs, stat_invals}), 64'(0));

        // Saturation on the 2-bit, 1-cycle-latency instance
        for (int i = 0; i < 5; i++) begin
            r2_cmd = mk_cmd(CMD_RD_DATA, 12'(i + 1)); r2_line = mk_line(12'h0, 3'd0, MESI_I);
            r2_valid = 1'b1;
            @(posedge clk); #1;
            r2_valid = 1'b0;
            cyc = 0;
            while (!r2_resp_valid && cyc < 10) begin
                @(posedge clk); #1; cyc++;
            end
            if (i == 0) check("sat_latency", 64'(cyc), 64'(1));
            r2_resp_ready = 1'b1;
            @(posedge clk); #1;
            r2_resp_ready = 1'b0;
            if (i == 2) check("sat_reads_at3", 64'(r2_reads), 64'(3));
        end
        check("sat_reads_final", 64'(r2_reads), 64'(3));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
